log_reservation_station: RTL and testbench



---
 rtl/log_reservation_station_if.sv | 60 ++++++
 rtl/log_reservation_station.sv | 166 ++++++++++++++++
 tb/tb_log_reservation_station.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/log_reservation_station_if.sv
// Decode types for the logical unit plus the dispatch / CDB / issue bundle
// of the logical reservation station. The package sits here so it is
// compiled ahead of every user.
package log_pkg;
   typedef enum logic [2:0] {
      LOG_AND, LOG_OR, LOG_XOR, LOG_NAND, LOG_NOR, LOG_EQV, LOG_ANDC, LOG_ORC
   } log_op_t;

   typedef struct packed {
      log_op_t op;
      logic    rc;
   } log_decode_t;
endpackage

interface log_rs_if #(parameter int RS_ID_WIDTH = 5);
   import log_pkg::*;

   // dispatch
   logic                   in_valid;
   logic                   in_ready;
   logic [4:0]             in_result_reg_addr;
   log_decode_t            in_control;
   logic [31:0]            in_op1, in_op2;
   logic                   in_op1_valid, in_op2_valid, in_so_valid;
   logic [RS_ID_WIDTH-1:0] in_op1_tag, in_op2_tag, in_so_tag;
   logic                   in_so;
   // common result bus
   logic                   cdb_valid;
   logic [RS_ID_WIDTH-1:0] cdb_rs_id;
   logic [31:0]            cdb_result;
   logic                   cdb_so;
   // issue
   logic                   out_valid;
   logic                   out_ready;
   logic [RS_ID_WIDTH-1:0] rs_id_out;
   logic [4:0]             result_reg_addr_out;
   logic [31:0]            op1, op2;
   logic                   so;
   log_decode_t            control;

   // dispatcher / CDB / logical-unit side
   modport master (
      output in_valid, in_result_reg_addr, in_control, in_op1, in_op2,
             in_op1_valid, in_op2_valid, in_so_valid, in_op1_tag, in_op2_tag,
             in_so_tag, in_so, cdb_valid, cdb_rs_id, cdb_result, cdb_so,
             out_ready,
      input  in_ready, out_valid, rs_id_out, result_reg_addr_out, op1, op2,
             so, control
   );

   // reservation station side
   modport slave (
      input  in_valid, in_result_reg_addr, in_control, in_op1, in_op2,
             in_op1_valid, in_op2_valid, in_so_valid, in_op1_tag, in_op2_tag,
             in_so_tag, in_so, cdb_valid, cdb_rs_id, cdb_result, cdb_so,
             out_ready,
      output in_ready, out_valid, rs_id_out, result_reg_addr_out, op1, op2,
             so, control
   );
endinterface

// File: rtl/log_reservation_station.sv
// Reservation station in front of the logical unit. Holds DEPTH dispatched
// instructions, snoops the CDB for pending operands / SO, and issues
// operand-complete slots over a valid/ready handshake.
// Optional macro LOG_RS_AGE_ORDER_EN: issue the oldest ready slot (age
// matrix) instead of the lowest-index ready slot.
module log_reservation_station
   import log_pkg::*;
#(
   parameter int RS_ID_WIDTH = 5,
   parameter int DEPTH       = 4,
   parameter int RS_ID_BASE  = 0
) (
   input logic     clk,
   input logic     rst,
   input logic     flush,
   log_rs_if.slave bus
);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0]       busy, op1_vld, op2_vld, so_vld;
   logic [31:0]            op1_q   [DEPTH];
   logic [31:0]            op2_q   [DEPTH];
   logic                   so_q    [DEPTH];
   logic [RS_ID_WIDTH-1:0] op1_tag [DEPTH];
   logic [RS_ID_WIDTH-1:0] op2_tag [DEPTH];
   logic [RS_ID_WIDTH-1:0] so_tag  [DEPTH];
   log_decode_t            ctrl_q  [DEPTH];
   logic [4:0]             dest_q  [DEPTH];

   logic [DEPTH-1:0] ready;
   logic [IW-1:0]    alloc_idx, pick, sel, lock_idx;
   logic             lock, out_valid, alloc_en, fire;
   logic             byp1, byp2, byps;

   assign ready     = busy & op1_vld & op2_vld & so_vld;
   assign alloc_en  = bus.in_valid & bus.in_ready & ~flush;
   assign out_valid = lock | (|ready);
   assign fire      = out_valid & bus.out_ready;
   assign sel       = lock ? lock_idx : pick;

   // operands arriving on the CDB in the allocate cycle are stored already valid
   assign byp1 = bus.cdb_valid & (bus.in_op1_tag == bus.cdb_rs_id);
   assign byp2 = bus.cdb_valid & (bus.in_op2_tag == bus.cdb_rs_id);
   assign byps = bus.cdb_valid & (bus.in_so_tag  == bus.cdb_rs_id);

   // lowest-index free slot takes the next dispatch
   always_comb begin
      alloc_idx = '0;
      for (int i = DEPTH-1; i >= 0; i--)
         if (!busy[i]) alloc_idx = IW'(i);
   end

`ifdef LOG_RS_AGE_ORDER_EN
   // age[i][j] set means slot i was allocated before slot j
   logic [DEPTH-1:0] age [DEPTH];

   // newly allocated slot becomes younger than every other slot
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) age[i] <= '0;
      end else if (alloc_en) begin
         for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH; j++)
               if (IW'(j) == alloc_idx)      age[i][j] <= (i != j);
               else if (IW'(i) == alloc_idx) age[i][j] <= 1'b0;
      end
   end

   // oldest ready slot: no other ready slot is older than it
   always_comb begin
      logic [DEPTH-1:0] older;
      pick  = '0;
      older = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) older[j] = age[j][i];
         if (ready[i] && ((ready & older) == '0)) pick = IW'(i);
      end
   end
`else
   // lowest-index ready slot
   always_comb begin
      pick = '0;
      for (int i = DEPTH-1; i >= 0; i--)
         if (ready[i]) pick = IW'(i);
   end
`endif

   // selection is frozen while an issue request is stalled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lock     <= 1'b0;
         lock_idx <= '0;
      end else if (flush) begin
         lock     <= 1'b0;
      end else if (out_valid && !bus.out_ready) begin
         lock     <= 1'b1;
         lock_idx <= sel;
      end else begin
         lock     <= 1'b0;
      end
   end

   // slot state: allocate, CDB wakeup, release on issue, flush
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy    <= '0;
         op1_vld <= '0;
         op2_vld <= '0;
         so_vld  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            op1_q[i]   <= '0;
            op2_q[i]   <= '0;
            so_q[i]    <= 1'b0;
            op1_tag[i] <= '0;
            op2_tag[i] <= '0;
            so_tag[i]  <= '0;
            ctrl_q[i]  <= '0;
            dest_q[i]  <= '0;
         end
      end else if (flush) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (bus.cdb_valid && busy[i]) begin
               if (!op1_vld[i] && op1_tag[i] == bus.cdb_rs_id) begin
                  op1_q[i]   <= bus.cdb_result;
                  op1_vld[i] <= 1'b1;
               end
               if (!op2_vld[i] && op2_tag[i] == bus.cdb_rs_id) begin
                  op2_q[i]   <= bus.cdb_result;
                  op2_vld[i] <= 1'b1;
               end
               if (!so_vld[i] && so_tag[i] == bus.cdb_rs_id) begin
                  so_q[i]    <= bus.cdb_so;
                  so_vld[i]  <= 1'b1;
               end
            end
            if (fire && sel == IW'(i)) busy[i] <= 1'b0;
            if (alloc_en && alloc_idx == IW'(i)) begin
               busy[i]    <= 1'b1;
               ctrl_q[i]  <= bus.in_control;
               dest_q[i]  <= bus.in_result_reg_addr;
               op1_tag[i] <= bus.in_op1_tag;
               op2_tag[i] <= bus.in_op2_tag;
               so_tag[i]  <= bus.in_so_tag;
               op1_vld[i] <= bus.in_op1_valid | byp1;
               op2_vld[i] <= bus.in_op2_valid | byp2;
               so_vld[i]  <= bus.in_so_valid  | byps;
               op1_q[i]   <= bus.in_op1_valid ? bus.in_op1 : bus.cdb_result;
               op2_q[i]   <= bus.in_op2_valid ? bus.in_op2 : bus.cdb_result;
               so_q[i]    <= bus.in_so_valid  ? bus.in_so  : bus.cdb_so;
            end
         end
      end
   end

   // issue outputs come straight from the selected slot, zero when idle
   assign bus.in_ready            = ~&busy;
   assign bus.out_valid           = out_valid;
   assign bus.rs_id_out           = out_valid ? RS_ID_WIDTH'(RS_ID_BASE + int'(sel)) : '0;
   assign bus.result_reg_addr_out = out_valid ? dest_q[sel] : '0;
   assign bus.op1                 = out_valid ? op1_q[sel]  : '0;
   assign bus.op2                 = out_valid ? op2_q[sel]  : '0;
   assign bus.so                  = out_valid ? so_q[sel]   : 1'b0;
   assign bus.control             = out_valid ? ctrl_q[sel] : '0;
endmodule

// File: tb/tb_log_reservation_station.sv
// Directed bench for log_reservation_station (DEPTH 4, RS IDs 16..19).
module tb_log_reservation_station;
   import log_pkg::*;

   localparam int BASE = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic flush = 1'b0;
   int   checks = 0;
   int   errors = 0;

   log_rs_if #(.RS_ID_WIDTH(5)) bus ();

   log_reservation_station #(.RS_ID_WIDTH(5), .DEPTH(4), .RS_ID_BASE(BASE)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic disp(input logic [31:0] a, input logic av, input logic [4:0] at,
                       input logic [31:0] b, input logic bv, input logic [4:0] bt,
                       input logic s, input logic sv, input logic [4:0] st,
                       input logic [4:0] d, input log_op_t op, input logic rc);
      bus.in_valid = 1'b1;
      bus.in_op1 = a; bus.in_op1_valid = av; bus.in_op1_tag = at;
      bus.in_op2 = b; bus.in_op2_valid = bv; bus.in_op2_tag = bt;
      bus.in_so  = s; bus.in_so_valid  = sv; bus.in_so_tag  = st;
      bus.in_result_reg_addr = d;
      bus.in_control.op = op;
      bus.in_control.rc = rc;
   endtask

   task automatic cdb(input logic [4:0] id, input logic [31:0] res, input logic s);
      bus.cdb_valid = 1'b1; bus.cdb_rs_id = id; bus.cdb_result = res; bus.cdb_so = s;
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.cdb_valid = 1'b0;
   endtask

   initial begin
      logic [4:0]  exp_id1, exp_id2;
      logic [31:0] exp_b1, exp_b2;
      idle();
      disp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, LOG_AND, 1'b0);
      idle();
      bus.cdb_rs_id = '0; bus.cdb_result = '0; bus.cdb_so = 1'b0;
      bus.out_ready = 1'b0;

      // reset state
      #12;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_rs_id", bus.rs_id_out, 0);
      chk("rst_dest", bus.result_reg_addr_out, 0);
      chk("rst_op1", bus.op1, 0);
      chk("rst_op2", bus.op2, 0);
      chk("rst_so", bus.so, 0);
      chk("rst_ctrl", bus.control, 0);
      tick();
      rst = 1'b1;
      tick();

      // all-valid dispatch issues next cycle
      bus.out_ready = 1'b1;
      disp(32'hF0F0_0000, 1, 0, 32'hFF00_FF00, 1, 0, 1, 1, 0, 5, LOG_AND, 1'b1);
      tick(); idle();
      chk("and_valid", bus.out_valid, 1);
      chk("and_op1", bus.op1, 32'hF0F0_0000);
      chk("and_op2", bus.op2, 32'hFF00_FF00);
      chk("and_so", bus.so, 1);
      chk("and_id", bus.rs_id_out, BASE);
      chk("and_dest", bus.result_reg_addr_out, 5);
      chk("and_ctrl", bus.control, 4'b0001);
      tick();
      chk("and_done", bus.out_valid, 0);

      // op2 pending on tag 7, woken by CDB two cycles later
      disp(32'h1, 1, 0, 32'h0, 0, 7, 0, 1, 0, 6, LOG_OR, 1'b0);
      tick(); idle();
      chk("pend_wait", bus.out_valid, 0);
      cdb(6, 32'hDEAD_BEEF, 1);
      tick(); idle();
      chk("pend_wrongtag", bus.out_valid, 0);
      cdb(7, 32'h1234_5678, 0);
      tick(); idle();
      chk("wake_valid", bus.out_valid, 1);
      chk("wake_op2", bus.op2, 32'h1234_5678);
      chk("wake_op1", bus.op1, 1);
      chk("wake_id", bus.rs_id_out, BASE);
      chk("wake_dest", bus.result_reg_addr_out, 6);
      chk("wake_ctrl", bus.control, 4'b0010);
      tick();
      chk("wake_done", bus.out_valid, 0);

      // op1 bypass in allocate cycle; SO woken afterwards
      disp(32'h0, 0, 3, 32'h0F, 1, 0, 0, 0, 9, 7, LOG_XOR, 1'b0);
      cdb(3, 32'hAAAA_5555, 0);
      tick(); idle();
      chk("byp_so_pend", bus.out_valid, 0);
      cdb(9, 32'h0, 1);
      tick(); idle();
      chk("byp_valid", bus.out_valid, 1);
      chk("byp_op1", bus.op1, 32'hAAAA_5555);
      chk("byp_so", bus.so, 1);
      tick();
      chk("byp_done", bus.out_valid, 0);

      // fill all slots with the consumer stalled
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         disp(32'h100 + i, 1, 0, 0, 1, 0, 0, 1, 0, 5'(i), LOG_NOR, 1'b0);
         tick();
      end
      disp(32'h1FF, 1, 0, 0, 1, 0, 0, 1, 0, 9, LOG_NOR, 1'b0);
      for (int k = 0; k < 5; k++) begin
         chk("full_in_ready", bus.in_ready, 0);
         chk("full_valid", bus.out_valid, 1);
         chk("full_id", bus.rs_id_out, BASE);
         chk("full_op1", bus.op1, 32'h100);
         tick();
      end
      idle();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("full_release_ready", bus.in_ready, 1);
      chk("full_next_id", bus.rs_id_out, BASE + 1);
      bus.out_ready = 1'b1;
      tick();
      chk("drain_id2", bus.rs_id_out, BASE + 2);
      chk("drain_op2", bus.op1, 32'h102);
      tick();
      chk("drain_id3", bus.rs_id_out, BASE + 3);
      tick();
      chk("drain_done", bus.out_valid, 0);

      // selection stays locked while stalled, even if a lower slot wakes
      bus.out_ready = 1'b0;
      disp(32'h0, 0, 10, 32'h20, 1, 0, 0, 1, 0, 1, LOG_AND, 1'b0);
      tick();
      disp(32'h30, 1, 0, 32'h40, 1, 0, 0, 1, 0, 2, LOG_AND, 1'b0);
      tick(); idle();
      chk("lock_id0", bus.rs_id_out, BASE + 1);
      cdb(10, 32'h77, 0);
      tick(); idle();
      chk("lock_id1", bus.rs_id_out, BASE + 1);
      chk("lock_op1", bus.op1, 32'h30);
      tick();
      chk("lock_id2", bus.rs_id_out, BASE + 1);
      bus.out_ready = 1'b1;
      tick();
      chk("lock_next_id", bus.rs_id_out, BASE);
      chk("lock_next_op1", bus.op1, 32'h77);
      tick();
      chk("lock_done", bus.out_valid, 0);

      // slot 2 older than slot 0, both woken by the same CDB broadcast
      bus.out_ready = 1'b0;
      disp(32'h200, 1, 0, 0, 1, 0, 0, 1, 0, 1, LOG_AND, 1'b0);
      tick();
      disp(32'h201, 1, 0, 0, 1, 0, 0, 1, 0, 1, LOG_AND, 1'b0);
      tick();
      disp(32'h0, 0, 13, 32'h300, 1, 0, 0, 1, 0, 1, LOG_AND, 1'b0);
      tick(); idle();
      chk("age_first", bus.rs_id_out, BASE);
      bus.out_ready = 1'b1;
      tick();
      chk("age_second", bus.rs_id_out, BASE + 1);
      disp(32'h0, 0, 13, 32'h400, 1, 0, 0, 1, 0, 1, LOG_AND, 1'b0);
      tick(); idle();
      chk("age_none", bus.out_valid, 0);
`ifdef LOG_RS_AGE_ORDER_EN
      exp_id1 = 5'(BASE + 2); exp_b1 = 32'h300;
      exp_id2 = 5'(BASE);     exp_b2 = 32'h400;
`else
      exp_id1 = 5'(BASE);     exp_b1 = 32'h400;
      exp_id2 = 5'(BASE + 2); exp_b2 = 32'h300;
`endif
      cdb(13, 32'h5A5A, 0);
      tick(); idle();
      chk("age_pick1_id", bus.rs_id_out, exp_id1);
      chk("age_pick1_op2", bus.op2, exp_b1);
      chk("age_pick1_op1", bus.op1, 32'h5A5A);
      tick();
      chk("age_pick2_id", bus.rs_id_out, exp_id2);
      chk("age_pick2_op2", bus.op2, exp_b2);
      tick();
      chk("age_done", bus.out_valid, 0);

      // flush with three busy slots and a simultaneous dispatch + CDB
      for (int i = 0; i < 3; i++) begin
         disp(32'h0, 0, 20, 32'h1, 1, 0, 0, 1, 0, 3, LOG_AND, 1'b0);
         tick();
      end
      disp(32'h9, 1, 0, 32'h9, 1, 0, 0, 1, 0, 3, LOG_AND, 1'b0);
      cdb(20, 32'h55, 0);
      flush = 1'b1;
      tick(); idle();
      flush = 1'b0;
      chk("flush_in_ready", bus.in_ready, 1);
      chk("flush_valid", bus.out_valid, 0);
      tick();
      chk("flush_valid2", bus.out_valid, 0);
      disp(32'h66, 1, 0, 32'h1, 1, 0, 0, 1, 0, 3, LOG_AND, 1'b0);
      tick(); idle();
      chk("flush_realloc_id", bus.rs_id_out, BASE);
      chk("flush_realloc_op1", bus.op1, 32'h66);

      // asynchronous reset in the middle of a stalled issue
      bus.out_ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("async_rst_valid", bus.out_valid, 0);
      chk("async_rst_ready", bus.in_ready, 1);
      chk("async_rst_op1", bus.op1, 0);
      tick();
      rst = 1'b1;
      tick();
      chk("post_rst_valid", bus.out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("FAIL timeout observed=stall expected=finish");
      $fatal(1, "timeout");
   end
endmodule
